// File: rtl/axis_credit_gate_if.sv
// Byte-wide AXI4-Stream link carrying R/G/B bytes into the credit gate.
// The master drives valid/data/last; the slave answers with ready.
interface axis_credit_gate_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_credit_gate.sv
// Credit-based admission stage in front of a pipeline with no backpressure:
// a byte is admitted only while a downstream FIFO slot is guaranteed for it.
module axis_credit_gate #(
    parameter int FIFO_DEPTH = 512,
    parameter int CREDIT_W   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    axis_credit_gate_if.slave   s_axis,
    output logic                pipe_valid_o,
    output logic [7:0]          pipe_data_o,
    input  logic                ret_i,
    output logic [CREDIT_W-1:0] credits_o,
    output logic [1:0]          phase_o,
    output logic                err_tlast_o,
    output logic                err_credit_o,
    input  logic                clr_err_i
);
    localparam logic [CREDIT_W-1:0] FULL_C = CREDIT_W'(FIFO_DEPTH);
    localparam logic [CREDIT_W-1:0] ONE_C  = CREDIT_W'(1);

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_e;

    logic [CREDIT_W-1:0] credits_q, credits_d;
    phase_e              phase_q, phase_d;
    logic                pipe_valid_q, pipe_valid_d;
    logic [7:0]          pipe_data_q, pipe_data_d;
    logic                err_tlast_q, err_tlast_d;
    logic                err_credit_q, err_credit_d;

    logic tready;
    logic acc;
    logic err_tlast_set;
    logic err_credit_set;

    // Ready depends only on registered credits, never on tvalid.
    assign tready        = (credits_q != '0);
    assign s_axis.tready = tready;
    assign acc           = s_axis.tvalid & tready;

    always_comb begin
        credits_d      = credits_q;
        err_credit_set = 1'b0;
        unique case ({acc, ret_i})
            2'b10: credits_d = credits_q - ONE_C;
            2'b01: begin
                if (credits_q == FULL_C) begin
                    err_credit_set = 1'b1;
                end else begin
                    credits_d = credits_q + ONE_C;
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    // A tlast on R or G resynchronises the phase to R; the byte still goes through.
    always_comb begin
        phase_d       = phase_q;
        err_tlast_set = 1'b0;
        if (acc) begin
            if (s_axis.tlast) begin
                err_tlast_set = (phase_q != PH_B);
                phase_d       = PH_R;
            end else begin
                unique case (phase_q)
                    PH_R:    phase_d = PH_G;
                    PH_G:    phase_d = PH_B;
                    default: phase_d = PH_R;
                endcase
            end
        end
    end

    always_comb begin
        pipe_valid_d = acc;
        pipe_data_d  = acc ? s_axis.tdata : pipe_data_q;
        // A set event in the same cycle as a clear keeps the flag raised.
        err_tlast_d  = err_tlast_set  | (err_tlast_q  & ~clr_err_i);
        err_credit_d = err_credit_set | (err_credit_q & ~clr_err_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q    <= FULL_C;
            phase_q      <= PH_R;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= 8'h00;
            err_tlast_q  <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            phase_q      <= phase_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            err_tlast_q  <= err_tlast_d;
            err_credit_q <= err_credit_d;
        end
    end

    assign credits_o    = credits_q;
    assign phase_o      = phase_q;
    assign pipe_valid_o = pipe_valid_q;
    assign pipe_data_o  = pipe_data_q;
    assign err_tlast_o  = err_tlast_q;
    assign err_credit_o = err_credit_q;
endmodule

// File: tb/tb_axis_credit_gate.sv
// Directed bench for axis_credit_gate: a behavioural credit/phase model predicts
// every output, and admitted bytes are queued and matched against the pipeline side.
module tb_axis_credit_gate;
    localparam int DEPTH = 512;
    localparam int CW    = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          pipe_valid_o;
    logic [7:0]    pipe_data_o;
    logic          ret_i;
    logic [CW-1:0] credits_o;
    logic [1:0]    phase_o;
    logic          err_tlast_o;
    logic          err_credit_o;
    logic          clr_err_i;

    axis_credit_gate_if s_axis_if ();

    axis_credit_gate #(
        .FIFO_DEPTH (DEPTH),
        .CREDIT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_axis_if),
        .pipe_valid_o (pipe_valid_o),
        .pipe_data_o  (pipe_data_o),
        .ret_i        (ret_i),
        .credits_o    (credits_o),
        .phase_o      (phase_o),
        .err_tlast_o  (err_tlast_o),
        .err_credit_o (err_credit_o),
        .clr_err_i    (clr_err_i)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         m_cred;
    int         m_phase;
    bit         m_errt;
    bit         m_errc;
    logic [7:0] m_last;
    int         n_acc;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cred  = DEPTH;
        m_phase = 0;
        m_errt  = 1'b0;
        m_errc  = 1'b0;
        m_last  = 8'h00;
        exp_q.delete();
    endtask

    task automatic check_state();
        chk("credits", 32'(credits_o), 32'(m_cred));
        chk("phase", 32'(phase_o), 32'(m_phase));
        chk("err_tlast", 32'(err_tlast_o), 32'(m_errt));
        chk("err_credit", 32'(err_credit_o), 32'(m_errc));
    endtask

    // One clock: drive at the falling edge, predict, then check after the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                         input logic r, input logic c);
        bit         acc;
        bit         set_t;
        bit         set_c;
        logic [7:0] e;
        s_axis_if.tvalid = v;
        s_axis_if.tdata  = d;
        s_axis_if.tlast  = l;
        ret_i            = r;
        clr_err_i        = c;
        chk("tready", 32'(s_axis_if.tready), 32'(m_cred != 0));
        acc   = v && (m_cred != 0);
        set_t = acc && l && (m_phase != 2);
        set_c = 1'b0;
        if (acc) begin
            exp_q.push_back(d);
            n_acc++;
        end
        if (acc && !r) begin
            m_cred--;
        end else if (!acc && r) begin
            if (m_cred == DEPTH) set_c = 1'b1;
            else m_cred++;
        end
        if (acc) m_phase = (l || m_phase == 2) ? 0 : m_phase + 1;
        m_errt = set_t || (m_errt && !c);
        m_errc = set_c || (m_errc && !c);
        @(negedge clk);
        chk("pipe_valid", 32'(pipe_valid_o), 32'(acc));
        if (acc) begin
            e = exp_q.pop_front();
            chk("pipe_data", 32'(pipe_data_o), 32'(e));
            m_last = e;
        end else begin
            chk("pipe_hold", 32'(pipe_data_o), 32'(m_last));
        end
        check_state();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = 8'h00;
        s_axis_if.tlast  = 1'b0;
        ret_i            = 1'b0;
        clr_err_i        = 1'b0;
        model_reset();
        n_acc = 0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_tready", 32'(s_axis_if.tready), 32'd1);
        chk("rst_pipe_valid", 32'(pipe_valid_o), 32'd0);
        chk("rst_pipe_data", 32'(pipe_data_o), 32'd0);
        check_state();

        // Fill: exactly DEPTH accepts, then ready drops
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_accepts", 32'(n_acc), 32'(DEPTH));
        chk("fill_credits", 32'(credits_o), 32'd0);
        chk("fill_tready", 32'(s_axis_if.tready), 32'd0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("fill_no_extra", 32'(n_acc), 32'(DEPTH));

        // Starved return: one credit lets exactly one byte through
        n_acc = 0;
        cycle(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h3E, 1'b0, 1'b0, 1'b0);
        chk("starve_accepts", 32'(n_acc), 32'd1);
        chk("starve_credits", 32'(credits_o), 32'd0);

        // Simultaneous accept and return at credits 5
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_acc = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b1, 1'b0);
        chk("simul_accepts", 32'(n_acc), 32'd10);
        chk("simul_credits", 32'(credits_o), 32'd5);

        // Framing: align to R, then bad tlast on G
        for (int i = 0; i < 3 && m_phase != 0; i++) cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h21, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        chk("frame_err_set", 32'(err_tlast_o), 32'd1);
        chk("frame_resync", 32'(phase_o), 32'd0);
        cycle(1'b1, 8'h31, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h32, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
        chk("frame_good_line", 32'(phase_o), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("frame_clr", 32'(err_tlast_o), 32'd0);
        cycle(1'b1, 8'h44, 1'b1, 1'b1, 1'b1);
        chk("frame_set_wins", 32'(err_tlast_o), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Credit overflow
        for (int i = 0; i < DEPTH && m_cred < DEPTH; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("ovf_full", 32'(credits_o), 32'(DEPTH));
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("ovf_err", 32'(err_credit_o), 32'd1);
        chk("ovf_sat", 32'(credits_o), 32'(DEPTH));
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("ovf_set_wins", 32'(err_credit_o), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(err_credit_o), 32'd0);

        // Asynchronous reset in the middle of a stream with errors raised
        cycle(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_credits", 32'(credits_o), 32'(DEPTH));
        chk("arst_tready", 32'(s_axis_if.tready), 32'd1);
        chk("arst_pipe_valid", 32'(pipe_valid_o), 32'd0);
        chk("arst_pipe_data", 32'(pipe_data_o), 32'd0);
        chk("arst_phase", 32'(phase_o), 32'd0);
        chk("arst_err_tlast", 32'(err_tlast_o), 32'd0);
        chk("arst_err_credit", 32'(err_credit_o), 32'd0);
        model_reset();
        s_axis_if.tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
